// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter.
// States, access sizes and the latched request bundle.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COMPLETE
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        write;
        logic [31:0] address;
        logic [1:0]  size;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-master single-port RAM arbiter: master 0 priority,
// bounded starvation for master 1, one access per two cycles.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [31:0]           m0_address,
    input  logic [1:0]            m0_data_size,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_grant,
    output logic                  m0_valid,
    output logic [31:0]           m0_rdata,
    output logic                  m0_error,

    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [31:0]           m1_address,
    input  logic [1:0]            m1_data_size,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_grant,
    output logic                  m1_valid,
    output logic [31:0]           m1_rdata,
    output logic                  m1_error,

    output logic                  ram_read,
    output logic                  ram_write,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [1:0]            ram_data_size,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    state_t        state, state_next;
    logic [WW-1:0] wait_cnt;
    logic          owner;
    req_t          lat;
    logic [31:0]   m0_rdata_q, m1_rdata_q;

    logic          decide, pick1, oor, issue, done;
    logic [31:0]   load_data;
    req_t          win_req;

    always_comb begin
        decide = 1'b0;
        if (!reset && (state == IDLE || state == COMPLETE))
            decide = m0_req || m1_req;
    end

    // Master 1 wins when alone or once its wait bound is reached.
    assign pick1 = m1_req && (!m0_req || wait_cnt == WAIT_MAX);

    assign m0_grant = decide && !pick1;
    assign m1_grant = decide && pick1;

    always_comb begin
        win_req.write   = m0_write;
        win_req.address = m0_address;
        win_req.size    = m0_data_size;
        win_req.wdata   = m0_wdata;
        if (pick1) begin
            win_req.write   = m1_write;
            win_req.address = m1_address;
            win_req.size    = m1_data_size;
            win_req.wdata   = m1_wdata;
        end
    end

    assign oor   = |(lat.address >> ADDR_WIDTH);
    assign issue = !reset && state == ISSUE && !oor;
    assign done  = !reset && state == COMPLETE;

    assign ram_read      = issue && !lat.write;
    assign ram_write     = issue && lat.write;
    assign ram_address   = lat.address[ADDR_WIDTH-1:0];
    assign ram_data_size = lat.size;
    assign ram_wdata     = lat.wdata;

    assign m0_valid  = done && !owner;
    assign m1_valid  = done && owner;
    assign m0_error  = m0_valid && oor;
    assign m1_error  = m1_valid && oor;
    assign load_data = oor ? 32'd0 : ram_rdata;

    // Completing loads and faults show data in the valid cycle itself.
    always_comb begin
        m0_rdata = m0_rdata_q;
        m1_rdata = m1_rdata_q;
        if (m0_valid && (!lat.write || oor))
            m0_rdata = load_data;
        if (m1_valid && (!lat.write || oor))
            m1_rdata = load_data;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (decide) state_next = ISSUE;
            ISSUE:    state_next = COMPLETE;
            COMPLETE: state_next = decide ? ISSUE : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            owner      <= 1'b0;
            lat        <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (decide) begin
                owner <= pick1;
                lat   <= win_req;
                if (pick1 || !m1_req)
                    wait_cnt <= '0;
                else if (wait_cnt != WAIT_MAX)
                    wait_cnt <= wait_cnt + WW'(1);
            end
            if (m0_valid && (!lat.write || oor))
                m0_rdata_q <= load_data;
            if (m1_valid && (!lat.write || oor))
                m1_rdata_q <= load_data;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a small word RAM model.
// Inputs change on the falling edge; outputs are checked 1 unit later.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [31:0] m0_address, m0_wdata, m1_address, m1_wdata;
    logic [1:0]  m0_data_size, m1_data_size;
    logic        m0_grant, m0_valid, m0_error;
    logic        m1_grant, m1_valid, m1_error;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_read, ram_write;
    logic [11:0] ram_address;
    logic [1:0]  ram_data_size;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory_arbiter #(.ADDR_WIDTH(12), .MAX_WAIT(3)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address),
        .m0_data_size(m0_data_size), .m0_wdata(m0_wdata),
        .m0_grant(m0_grant), .m0_valid(m0_valid),
        .m0_rdata(m0_rdata), .m0_error(m0_error),
        .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address),
        .m1_data_size(m1_data_size), .m1_wdata(m1_wdata),
        .m1_grant(m1_grant), .m1_valid(m1_valid),
        .m1_rdata(m1_rdata), .m1_error(m1_error),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_address(ram_address), .ram_data_size(ram_data_size),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always @(posedge clock) begin
        if (reset) begin
            ram_rdata <= 32'd0;
            mem[4]    <= 32'hDEADBEEF;
        end else begin
            if (ram_write) mem[ram_address[11:2]] <= ram_wdata;
            if (ram_read)  ram_rdata <= mem[ram_address[11:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic run_contention(input int n);
        logic e0, e1;
        for (int i = 0; i < 2 * n; i++) begin
            cyc();
            m0_req = 1'b1; m0_write = 1'b0; m0_address = 32'h010;
            m1_req = 1'b1; m1_write = 1'b0; m1_address = 32'h020;
            #1;
            e1 = (i % 2 == 0) && ((i / 2) % 4 == 3);
            e0 = (i % 2 == 0) && !e1;
            chk($sformatf("cont_g0_%0d", i), 32'(m0_grant), 32'(e0));
            chk($sformatf("cont_g1_%0d", i), 32'(m1_grant), 32'(e1));
            if (i % 2 == 1) chk($sformatf("cont_rd_%0d", i), 32'(ram_read), 32'd1);
        end
        cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        #1;
        chk("cont_tail_g", 32'({m0_grant, m1_grant}), 32'd0);
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 0; m0_write = 0; m0_address = 0; m0_data_size = 2; m0_wdata = 0;
        m1_req = 0; m1_write = 0; m1_address = 0; m1_data_size = 2; m1_wdata = 0;
        cyc(); cyc(); #1;
        chk("rst_grants", 32'({m0_grant, m1_grant, m0_valid, m1_valid}), 32'd0);
        chk("rst_strobes", 32'({ram_read, ram_write, m0_error, m1_error}), 32'd0);
        chk("rst_addr", 32'(ram_address), 32'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);

        // single load
        cyc(); reset = 1'b0;
        m0_req = 1; m0_write = 0; m0_address = 32'h010; m0_data_size = 2;
        #1;
        chk("ld_grant", 32'(m0_grant), 32'd1);
        chk("ld_g1", 32'(m1_grant), 32'd0);
        chk("ld_no_rd_t", 32'(ram_read), 32'd0);
        cyc(); m0_req = 0; #1;
        chk("ld_rd_t1", 32'(ram_read), 32'd1);
        chk("ld_addr", 32'(ram_address), 32'h010);
        chk("ld_nv_t1", 32'(m0_valid), 32'd0);
        cyc(); #1;
        chk("ld_valid", 32'(m0_valid), 32'd1);
        chk("ld_rdata", m0_rdata, 32'hDEADBEEF);
        chk("ld_err", 32'(m0_error), 32'd0);
        chk("ld_rd_off", 32'(ram_read), 32'd0);
        cyc(); #1;
        chk("ld_valid_off", 32'(m0_valid), 32'd0);
        chk("ld_hold", m0_rdata, 32'hDEADBEEF);

        // store then load, back-to-back
        cyc();
        m1_req = 1; m1_write = 1; m1_address = 32'h020; m1_wdata = 32'h12345678;
        #1;
        chk("st_grant", 32'(m1_grant), 32'd1);
        cyc(); m1_req = 0; m1_write = 0; m1_wdata = 0; #1;
        chk("st_wr", 32'(ram_write), 32'd1);
        chk("st_nrd", 32'(ram_read), 32'd0);
        chk("st_wdata", ram_wdata, 32'h12345678);
        chk("st_size", 32'(ram_data_size), 32'd2);
        cyc(); m1_req = 1; m1_write = 0; m1_address = 32'h020; #1;
        chk("st_wr_off", 32'(ram_write), 32'd0);
        chk("st_valid", 32'(m1_valid), 32'd1);
        chk("st_rdata_keep", m1_rdata, 32'd0);
        chk("st_b2b_grant", 32'(m1_grant), 32'd1);
        cyc(); m1_req = 0; #1;
        chk("st_ld_rd", 32'(ram_read), 32'd1);
        cyc(); #1;
        chk("st_ld_valid", 32'(m1_valid), 32'd1);
        chk("st_ld_rdata", m1_rdata, 32'h12345678);
        cyc();

        // contention: m0,m0,m0,m1 repeating
        run_contention(8);

        // out of range
        cyc(); m0_req = 1; m0_write = 0; m0_address = 32'h00001000; #1;
        chk("oor_grant", 32'(m0_grant), 32'd1);
        cyc(); m0_req = 0; #1;
        chk("oor_nostrobe", 32'({ram_read, ram_write}), 32'd0);
        cyc(); #1;
        chk("oor_valid", 32'(m0_valid), 32'd1);
        chk("oor_err", 32'(m0_error), 32'd1);
        chk("oor_rdata", m0_rdata, 32'd0);
        cyc();

        // reset while a read is issued
        cyc(); m0_req = 1; m0_address = 32'h010; #1;
        chk("rsti_grant", 32'(m0_grant), 32'd1);
        cyc(); m0_req = 0; #1;
        chk("rsti_rd", 32'(ram_read), 32'd1);
        reset = 1'b1;
        cyc(); #1;
        chk("rsti_valid", 32'({m0_valid, m1_valid, m0_grant, m1_grant}), 32'd0);
        chk("rsti_strobe", 32'({ram_read, ram_write}), 32'd0);
        chk("rsti_addr", 32'(ram_address), 32'd0);
        chk("rsti_m1rd", m1_rdata, 32'd0);
        cyc(); reset = 1'b0; #1;
        chk("rsti_after_valid", 32'(m0_valid), 32'd0);
        m1_req = 1; m1_write = 0; m1_address = 32'h020; #1;
        chk("rsti_fresh_g", 32'(m1_grant), 32'd1);
        cyc(); m1_req = 0; cyc(); #1;
        chk("rsti_fresh_v", 32'(m1_valid), 32'd1);
        chk("rsti_fresh_d", m1_rdata, 32'h12345678);
        cyc();

        // withdrawal and wait counter clearing
        cyc(); m0_req = 1; m0_address = 32'h010; #1;
        chk("wd_g0", 32'(m0_grant), 32'd1);
        cyc(); m0_req = 0; m1_req = 1; m1_address = 32'h020; #1;
        chk("wd_issue_g1", 32'(m1_grant), 32'd0);
        cyc(); m0_req = 1; m1_req = 1; #1;
        chk("wd_c_g0", 32'(m0_grant), 32'd1);
        chk("wd_c_g1", 32'(m1_grant), 32'd0);
        chk("wd_c_v0", 32'(m0_valid), 32'd1);
        cyc(); m0_req = 0; m1_req = 0; #1;
        chk("wd_d_g1", 32'(m1_grant), 32'd0);
        cyc(); m0_req = 1; #1;
        chk("wd_e_g0", 32'(m0_grant), 32'd1);
        chk("wd_e_g1", 32'(m1_grant), 32'd0);
        cyc(); m0_req = 0;
        cyc(); #1;
        chk("wd_g_g1", 32'(m1_grant), 32'd0);
        run_contention(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
